// File: rtl/imm_pkg.sv
// Shared format codes, opcode patterns and counter width for the
// immediate-extend pipeline.
package imm_pkg;

   localparam int CNT_W = 16;
   localparam int OP_W  = 11;

   typedef enum logic [2:0] {
      FMT_D    = 3'd0,
      FMT_CB   = 3'd1,
      FMT_B    = 3'd2,
      FMT_SH   = 3'd3,
      FMT_I    = 3'd4,
      FMT_IW   = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [OP_W-1:0] val;
      logic [OP_W-1:0] msk;
   } pat_t;

   // Opcode = Instr[31:21]; mask bits of 0 are don't-care.
   localparam pat_t PAT_D  = '{val: 11'b11111000000, msk: 11'b11111111101};
   localparam pat_t PAT_CB = '{val: 11'b10110100000, msk: 11'b11111111000};
   localparam pat_t PAT_B  = '{val: 11'b00010100000, msk: 11'b11111100000};
   localparam pat_t PAT_SH = '{val: 11'b11010011010, msk: 11'b11111111110};
   localparam pat_t PAT_I  = '{val: 11'b10010001000, msk: 11'b10011111101};
   localparam pat_t PAT_IW = '{val: 11'b11010010100, msk: 11'b11111111100};

   function automatic logic op_hit(input logic [OP_W-1:0] op,
                                   input pat_t p);
      return (op & p.msk) == p.val;
   endfunction

endpackage

// File: rtl/imm_format_decode.sv
// Combinational opcode-to-format decode and immediate extraction.
// IW (MOVZ/MOVK) format is built only when IMM_EXTEND_IW_EN is defined.
module imm_format_decode
   import imm_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [31:0]       i_dec_instr,
   output fmt_e              o_dec_fmt,
   input  logic [31:0]       i_ext_instr,
   input  fmt_e              i_ext_fmt,
   output logic [DATA_W-1:0] o_ext_imm
);

   logic [OP_W-1:0] w_op;
   logic            w_iw_ok;
   logic [63:0]     w_imm;
   logic            w_unused_bits;

   assign w_op          = i_dec_instr[31:21];
   assign w_unused_bits = ^{i_ext_instr[31:26], i_dec_instr[20:0]};

`ifdef IMM_EXTEND_IW_EN
   // A 32-bit result cannot hold a half-word shift of 32 or 48.
   assign w_iw_ok = op_hit(w_op, PAT_IW) &&
                    !(DATA_W == 32 && i_dec_instr[22]);
`else
   assign w_iw_ok = 1'b0;
`endif

   always_comb begin
      o_dec_fmt = FMT_NONE;
      if (op_hit(w_op, PAT_D))
         o_dec_fmt = FMT_D;
      else if (op_hit(w_op, PAT_CB))
         o_dec_fmt = FMT_CB;
      else if (op_hit(w_op, PAT_B))
         o_dec_fmt = FMT_B;
      else if (op_hit(w_op, PAT_SH))
         o_dec_fmt = FMT_SH;
      else if (w_iw_ok)
         o_dec_fmt = FMT_IW;
      else if (op_hit(w_op, PAT_I))
         o_dec_fmt = FMT_I;
   end

   always_comb begin
      w_imm = '0;
      unique case (i_ext_fmt)
         FMT_D:
            w_imm = {{55{i_ext_instr[20]}}, i_ext_instr[20:12]};
         FMT_CB:
            w_imm = {{43{i_ext_instr[23]}}, i_ext_instr[23:5], 2'b00};
         FMT_B:
            w_imm = {{36{i_ext_instr[25]}}, i_ext_instr[25:0], 2'b00};
         FMT_SH:
            w_imm = {58'd0, i_ext_instr[15:10]};
         FMT_I:
            w_imm = {52'd0, i_ext_instr[21:10]};
`ifdef IMM_EXTEND_IW_EN
         FMT_IW:
            w_imm = {48'd0, i_ext_instr[20:5]} <<
                    {i_ext_instr[22:21], 4'b0000};
`endif
         default:
            w_imm = '0;
      endcase
   end

   assign o_ext_imm = w_imm[DATA_W-1:0];

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready pipeline around imm_format_decode.
// Optional IW format: define IMM_EXTEND_IW_EN.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 8
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [31:0]       Instr,
   input  logic [TAG_W-1:0]  InTag,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] BusImm,
   output logic [2:0]        Fmt,
   output logic              Illegal,
   output logic [TAG_W-1:0]  OutTag,
   output logic [CNT_W-1:0]  IllegalCnt
);

   logic              r_s1_valid;
   logic [31:0]       r_s1_instr;
   logic [TAG_W-1:0]  r_s1_tag;
   fmt_e              r_s1_fmt;
   logic              r_s2_valid;
   logic [DATA_W-1:0] r_imm;
   fmt_e              r_fmt;
   logic              r_ill;
   logic [TAG_W-1:0]  r_tag;
   logic [CNT_W-1:0]  r_cnt;

   fmt_e              w_dec_fmt;
   logic [DATA_W-1:0] w_imm;
   logic              w_s1_adv;
   logic              w_in_xfer;
   logic              w_out_xfer;

   imm_format_decode #(
      .DATA_W (DATA_W)
   ) u_dec (
      .i_dec_instr (Instr),
      .o_dec_fmt   (w_dec_fmt),
      .i_ext_instr (r_s1_instr),
      .i_ext_fmt   (r_s1_fmt),
      .o_ext_imm   (w_imm)
   );

   assign w_s1_adv   = !r_s2_valid || OutReady;
   assign InReady    = !r_s1_valid || w_s1_adv;
   assign w_in_xfer  = InValid && InReady;
   assign w_out_xfer = r_s2_valid && OutReady;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_s1_valid <= 1'b0;
         r_s1_instr <= '0;
         r_s1_tag   <= '0;
         r_s1_fmt   <= FMT_NONE;
      end else if (w_in_xfer) begin
         r_s1_valid <= 1'b1;
         r_s1_instr <= Instr;
         r_s1_tag   <= InTag;
         r_s1_fmt   <= w_dec_fmt;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Stage 2 holds its contents whenever the consumer stalls.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_s2_valid <= 1'b0;
         r_imm      <= '0;
         r_fmt      <= FMT_NONE;
         r_ill      <= 1'b0;
         r_tag      <= '0;
      end else if (w_s1_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_imm <= w_imm;
            r_fmt <= r_s1_fmt;
            r_ill <= (r_s1_fmt == FMT_NONE);
            r_tag <= r_s1_tag;
         end
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         r_cnt <= '0;
      else if (w_out_xfer && r_ill && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end

   assign OutValid   = r_s2_valid;
   assign BusImm     = r_imm;
   assign Fmt        = r_fmt;
   assign Illegal    = r_ill;
   assign OutTag     = r_tag;
   assign IllegalCnt = r_cnt;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe against a pattern-string
// reference model; honours IMM_EXTEND_IW_EN like the design.
module tb_imm_extend_pipe;

   localparam int DW = 64;
   localparam int TW = 8;

   logic          CLK = 1'b0;
   logic          Reset = 1'b1;
   logic          InValid = 1'b0;
   logic          InReady;
   logic [31:0]   Instr = '0;
   logic [TW-1:0] InTag = '0;
   logic          OutValid;
   logic          OutReady = 1'b1;
   logic [DW-1:0] BusImm;
   logic [2:0]    Fmt;
   logic          Illegal;
   logic [TW-1:0] OutTag;
   logic [15:0]   IllegalCnt;

   imm_extend_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .InValid    (InValid),
      .InReady    (InReady),
      .Instr      (Instr),
      .InTag      (InTag),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .BusImm     (BusImm),
      .Fmt        (Fmt),
      .Illegal    (Illegal),
      .OutTag     (OutTag),
      .IllegalCnt (IllegalCnt)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [7:0]  tag;
   } res_t;

   res_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   mcnt  = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic bit pm(input logic [10:0] op, input string p);
      for (int i = 0; i < 11; i++) begin
         if (p[i] != "X" && ((p[i] == "1") != op[10-i]))
            return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic res_t model(input logic [31:0] x,
                                  input logic [7:0] tag);
      res_t   r;
      longint v;
      int     f;
      bit     iw_en;
      logic [10:0] op;
`ifdef IMM_EXTEND_IW_EN
      iw_en = 1'b1;
`else
      iw_en = 1'b0;
`endif
      op = x[31:21];
      v  = 0;
      if (pm(op, "111110000X0")) begin
         f = 0;
         v = longint'(x[20:12]);
         if (x[20]) v = v - 512;
      end else if (pm(op, "10110100XXX")) begin
         f = 1;
         v = longint'(x[23:5]) * 4;
         if (x[23]) v = v - 2097152;
      end else if (pm(op, "000101XXXXX")) begin
         f = 2;
         v = longint'(x[25:0]) * 4;
         if (x[25]) v = v - 268435456;
      end else if (pm(op, "1101001101X")) begin
         f = 3;
         v = longint'(x[15:10]);
      end else if (iw_en && pm(op, "110100101XX") &&
                   !(DW == 32 && x[22])) begin
         f = 5;
         v = longint'(x[20:5]) << (16 * int'(x[22:21]));
      end else if (pm(op, "1XX100010X0")) begin
         f = 4;
         v = longint'(x[21:10]);
      end else begin
         f = 7;
      end
      r.imm = v;
      r.fmt = f[2:0];
      r.ill = (f == 7);
      r.tag = tag;
      return r;
   endfunction

   function automatic logic [31:0] gen();
      string p;
      logic [31:0] x;
      int k;
      x = $urandom;
      k = $urandom_range(0, 7);
      case (k)
         0: p = "111110000X0";
         1: p = "10110100XXX";
         2: p = "000101XXXXX";
         3: p = "1101001101X";
         4: p = "1XX100010X0";
         5: p = "110100101XX";
         default: return x;
      endcase
      for (int i = 0; i < 11; i++) begin
         if (p[i] == "1") x[31-i] = 1'b1;
         else if (p[i] == "0") x[31-i] = 1'b0;
      end
      return x;
   endfunction

   // Scoreboard: push on input transfer, compare head while OutValid.
   always @(negedge CLK) begin
      res_t e;
      if (Reset) begin
         q.delete();
         mcnt = 0;
         chk("rst_outvalid", OutValid, 0);
         chk("rst_inready", InReady, 1);
      end else begin
         chk("illegal_cnt", IllegalCnt, mcnt);
         if (OutValid) begin
            if (q.size() == 0) begin
               chk("stale_out", OutValid, 0);
            end else begin
               e = q[0];
               chk("out_imm", BusImm, e.imm);
               chk("out_fmt", Fmt, e.fmt);
               chk("out_ill", Illegal, e.ill);
               chk("out_tag", OutTag, e.tag);
               if (OutReady) begin
                  void'(q.pop_front());
                  if (e.ill && mcnt < 65535) mcnt++;
               end
            end
         end
         if (InValid && InReady) q.push_back(model(Instr, InTag));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic lat_test(input logic [31:0] ins, input logic [7:0] tag,
                           input logic [63:0] eimm, input logic [2:0] efmt,
                           input logic eill);
      OutReady = 1'b1;
      InValid  = 1'b1;
      Instr    = ins;
      InTag    = tag;
      tick();
      InValid = 1'b0;
      @(negedge CLK);
      chk("lat_early", OutValid, 0);
      @(negedge CLK);
      chk("lat_valid", OutValid, 1);
      chk("lat_imm", BusImm, eimm);
      chk("lat_fmt", Fmt, efmt);
      chk("lat_ill", Illegal, eill);
      chk("lat_tag", OutTag, tag);
      tick();
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      InValid  = 1'b0;
      OutReady = 1'b1;
      while (q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk(nm, q.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] st [3];
      logic [11:0] ovb;
      logic [63:0] snap_imm;
      logic [7:0]  snap_tag;
      int idx;
      int acc;
      res_t m;

      repeat (2) tick();
      chk("rst_busimm", BusImm, 0);
      chk("rst_fmt", Fmt, 7);
      chk("rst_ill", Illegal, 0);
      chk("rst_tag", OutTag, 0);
      chk("rst_cnt", IllegalCnt, 0);
      Reset = 1'b0;

      // First cycle after release must accept.
      lat_test(32'hF85F_0000, 8'h11, 64'hFFFF_FFFF_FFFF_FFF0, 3'd0, 1'b0);

      m = model(32'hF85F_0000, 8'h00);
      chk("pin_d_neg", m.imm, 64'hFFFF_FFFF_FFFF_FFF0);
      m = model(32'hF84F_0000, 8'h00);
      chk("pin_d_pos", m.imm, 64'h0000_0000_0000_00F0);
      m = model(32'h17FF_FFFF, 8'h00);
      chk("pin_b_imm", m.imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("pin_b_fmt", m.fmt, 3'd2);

      lat_test(32'hF84F_0000, 8'h12, 64'h0000_0000_0000_00F0, 3'd0, 1'b0);
      lat_test(32'h17FF_FFFF, 8'h22, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
`ifdef IMM_EXTEND_IW_EN
      lat_test(32'hD2A2_4680, 8'h33, 64'h0000_0000_1234_0000, 3'd5, 1'b0);
      chk("movz_illcnt", IllegalCnt, 0);
`else
      lat_test(32'hD2A2_4680, 8'h33, 64'h0, 3'd7, 1'b1);
      chk("movz_illcnt", IllegalCnt, 1);
`endif

      // Back-to-back stream: 8 results on 8 consecutive cycles.
      ovb = '0;
      for (int c = 0; c < 12; c++) begin
         InValid = (c < 8);
         Instr   = 32'h1400_0000 + c * 32'h0001_0003;
         InTag   = 8'h40 + 8'(c);
         @(negedge CLK);
         ovb[c] = OutValid;
         tick();
      end
      InValid = 1'b0;
      chk("b2b_pattern", ovb, 12'h3FC);

      // Stall: 3 offered, 2 accepted, outputs frozen.
      st[0] = 32'h9100_0000 | 32'h0012_3400;
      st[1] = 32'hD340_FC00;
      st[2] = 32'hB480_0FE0;
      idx = 0;
      acc = 0;
      snap_imm = '0;
      snap_tag = '0;
      OutReady = 1'b0;
      for (int c = 0; c < 5; c++) begin
         InValid = 1'b1;
         Instr   = st[idx];
         InTag   = 8'h51 + 8'(idx);
         @(negedge CLK);
         if (InReady) acc++;
         if (c == 2) begin
            snap_imm = BusImm;
            snap_tag = OutTag;
         end else if (c > 2) begin
            chk("stall_hold_imm", BusImm, snap_imm);
            chk("stall_hold_tag", OutTag, snap_tag);
            chk("stall_hold_ov", OutValid, 1);
         end
         tick();
         if (InReady == 1'b0 && acc == 2) idx = 2;
         else if (idx < 2) idx = acc;
      end
      chk("stall_accepted", acc, 2);
      chk("stall_inready", InReady, 0);
      OutReady = 1'b1;
      @(negedge CLK);
      chk("drain_accept", InReady, 1);
      tick();
      InValid = 1'b0;
      drain("stall_drain");

      // Reset with both stages full.
      OutReady = 1'b0;
      for (int c = 0; c < 3; c++) begin
         InValid = 1'b1;
         Instr   = 32'h17FF_0000 + c;
         InTag   = 8'h60 + 8'(c);
         tick();
      end
      #2;
      Reset = 1'b1;
      #1;
      chk("rst_async_ov", OutValid, 0);
      chk("rst_async_rdy", InReady, 1);
      InValid = 1'b0;
      tick();
      tick();
      Reset    = 1'b0;
      OutReady = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         chk("post_rst_no_out", OutValid, 0);
      end
      tick();

      // Saturating illegal counter.
      InValid  = 1'b1;
      Instr    = 32'h0;
      InTag    = 8'hEE;
      OutReady = 1'b1;
      repeat (65532) tick();
      InValid = 1'b0;
      repeat (3) tick();
      chk("sat_pre", IllegalCnt, 16'hFFFC);
      InValid = 1'b1;
      repeat (6) tick();
      InValid = 1'b0;
      repeat (3) tick();
      chk("sat_hold", IllegalCnt, 16'hFFFF);
      Reset = 1'b1;
      tick();
      chk("sat_rst", IllegalCnt, 0);
      Reset = 1'b0;
      tick();

      // Randomized traffic with random back-pressure.
      for (int c = 0; c < 3000; c++) begin
         InValid  = ($urandom_range(0, 3) != 0);
         Instr    = gen();
         InTag    = 8'($urandom);
         OutReady = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain("rand_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
